auto_song_player: RTL
=====================

# auto_song_player

Parametrised automatic song sequencer for the FPGA piano. It plays a song stored as (note, duration, end-flag) entries in an internal writable memory, advancing on a one-cycle beat-enable pulse. It drives the shared 4-bit note code into the tone generator and a one-hot key LED display. It supports multiple songs by base address, loop mode, pause, stop, and runtime song loading.

## Interface
- ADDR_W, 7, song memory address width; depth is 2^ADDR_W entries.
- DUR_W, 3, duration field width; an entry lasts DUR+1 beats (1..2^DUR_W).
- Entry format, width DUR_W+5: bit [DUR_W+4] is END, bits [DUR_W+3:4] are DUR, bits [3:0] are NOTE.
- Note codes: 0 C5, 1 B, 2 A, 3 G, 4 F, 5 E, 6 D, 7 C4, 8 none; 9..15 are invalid.

Ports:
- CLK  in  1  system clock; all logic runs on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle pulse; (re)starts playback at SONG_BASE.
- STOP  in  1  one-cycle pulse; aborts playback.
- PAUSE  in  1  level; while high, beat counting is frozen.
- LOOP  in  1  level; sampled when the END entry completes.
- SONG_BASE  in  ADDR_W  first entry of the selected song; sampled on START and on loop.
- BEAT_TICK  in  1  one-cycle beat enable. Consecutive pulses are at least 3 cycles apart.
- WR_EN  in  1  memory write strobe.
- WR_ADDR  in  ADDR_W  write address.
- WR_DATA  in  DUR_W+5  entry to write.
- note  out  4  current note code, registered.
- Led  out  8  combinational decode of note.
- BUSY  out  1  high in any state other than IDLE.
- DONE  out  1  one-cycle pulse when a non-looping song ends.
- POS  out  ADDR_W  address of the entry currently playing or being fetched.

## Operation
- Memory: single-port write, synchronous read, 1-cycle read latency, read-first on a same-address collision. The contents are undefined after configuration and are not cleared by reset.
- FSM states: IDLE, FETCH, LOAD, PLAY.
- IDLE + START: POS<=SONG_BASE, go to FETCH.
- FETCH: the read is issued at POS; go to LOAD.
- LOAD: latch note<=NOTE, dur<=DUR, end<=END, beat_cnt<=0; go to PLAY.
- PLAY, on BEAT_TICK with PAUSE low:
  - If beat_cnt==dur, the entry is complete:
    - END=0: POS<=POS+1 (wraps from 2^ADDR_W-1 to 0), go to FETCH.
    - END=1 and LOOP=1: POS<=SONG_BASE, go to FETCH.
    - END=1 and LOOP=0: go to IDLE, note<=8, DONE=1 for one cycle.
  - Otherwise beat_cnt<=beat_cnt+1.
- BEAT_TICK arriving in FETCH or LOAD is ignored.
- During FETCH and LOAD, note holds its previous value, so note transitions are gapless.
- PAUSE high: BEAT_TICK is ignored in PLAY; note, POS and beat_cnt hold. FETCH and LOAD still complete.
- STOP, from any state: next edge goes to IDLE with note<=8, beat_cnt<=0. POS holds. DONE is not asserted.
- Priority: STOP > START > beat logic. START in any non-IDLE state restarts from SONG_BASE via FETCH.
- Invalid NOTE codes are played as-is.
- Led decode:
  - code k in 0..7: Led = 8'b1 << (7-k), i.e. C4 drives Led[0] and C5 drives Led[7].
  - code 8: Led = 8'h00.
  - codes 9..15: Led = 8'hFF.

## Timing
- Reset values (asynchronous, immediate): state IDLE, note=8, Led=8'h00, BUSY=0, DONE=0, POS=0, beat_cnt=0.
- A RESET_N assertion in any state gives these values immediately. Playback resumes only on a new START.
- START sampled at edge k: BUSY=1 and POS=SONG_BASE after edge k; new note valid after edge k+2.
- Entry completion tick at edge t: new note valid after edge t+2.
- An entry lasts exactly DUR+1 accepted ticks, counted from the first accepted tick after LOAD.
- Non-looping end tick at edge t: note=8, BUSY=0, DONE=1 after edge t; DONE=0 after edge t+1.
- STOP at edge k: note=8 and BUSY=0 after edge k.
- A write at edge k is visible to any fetch issued after edge k. A same-cycle read returns the old data.

## Test plan
- Load entries 0..2 = {0,1,7}, {0,0,5}, {1,2,3} with LOOP=0, then START with SONG_BASE=0 and ticks every 4 cycles. Required:
  - note sequence is 7 for 2 ticks, 5 for 1 tick, 3 for 3 ticks, then 8;
  - Led shows 01, 04, 10, then 00;
  - DONE pulses once and BUSY falls on the same edge.
- Same song with LOOP=1: after the third entry, note returns to 7 and POS=0; DONE is never asserted.
- Assert PAUSE for 5 ticks mid-entry: note and POS are frozen. After release, the entry completes after the remaining tick count only.
- Assert STOP and START in the same cycle during PLAY: goes to IDLE, note=8, BUSY=0, DONE=0. A later START with SONG_BASE=0x40 plays from entry 0x40.
- Last entry at 0x7F with END=0: POS wraps to 0x00 and the note at 0x00 plays.
- Assert RESET_N low mid-entry: note=8, Led=00, POS=0 immediately. The memory contents are retained, and a replay matches the first test.

Source files
------------

// File: rtl/auto_song_player.sv
// rtl/auto_song_player.sv - automatic song sequencer with writable song memory and LED note decode
module auto_song_player #(
  parameter int ADDR_W = 7,
  parameter int DUR_W  = 3
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic              STOP,
  input  logic              PAUSE,
  input  logic              LOOP,
  input  logic [ADDR_W-1:0] SONG_BASE,
  input  logic              BEAT_TICK,
  input  logic              WR_EN,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [DUR_W+4:0]  WR_DATA,
  output logic [3:0]        note,
  output logic [7:0]        Led,
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W-1:0] POS
);

  localparam int EW = DUR_W + 5;
  localparam logic [3:0] NOTE_NONE = 4'd8;

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, PLAY} state_t;

  state_t            state, state_n;
  logic [EW-1:0]     mem [0:(1<<ADDR_W)-1];
  logic [EW-1:0]     rd_data;
  logic [DUR_W-1:0]  dur, dur_n;
  logic [DUR_W-1:0]  beat_cnt, cnt_n;
  logic              end_flag, end_n;
  logic [3:0]        note_n;
  logic [ADDR_W-1:0] pos_n;
  logic              done_n;

  // Song memory: contents survive reset; the read is taken only in FETCH and
  // returns the pre-write data when the same address is written that cycle.
  always_ff @(posedge CLK) begin
    if (WR_EN) mem[WR_ADDR] <= WR_DATA;
    if (state == FETCH) rd_data <= mem[POS];
  end

  // State and playback registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      POS      <= '0;
      note     <= NOTE_NONE;
      dur      <= '0;
      end_flag <= 1'b0;
      beat_cnt <= '0;
      DONE     <= 1'b0;
    end else begin
      state    <= state_n;
      POS      <= pos_n;
      note     <= note_n;
      dur      <= dur_n;
      end_flag <= end_n;
      beat_cnt <= cnt_n;
      DONE     <= done_n;
    end
  end

  // Next-state logic: STOP beats START, START beats beat counting.
  always_comb begin
    state_n = state;
    pos_n   = POS;
    note_n  = note;
    dur_n   = dur;
    end_n   = end_flag;
    cnt_n   = beat_cnt;
    done_n  = 1'b0;
    if (STOP) begin
      state_n = IDLE;
      note_n  = NOTE_NONE;
      cnt_n   = '0;
    end else if (START) begin
      state_n = FETCH;
      pos_n   = SONG_BASE;
    end else begin
      case (state)
        FETCH: state_n = LOAD;
        LOAD: begin
          note_n  = rd_data[3:0];
          dur_n   = rd_data[DUR_W+3:4];
          end_n   = rd_data[EW-1];
          cnt_n   = '0;
          state_n = PLAY;
        end
        PLAY: begin
          if (BEAT_TICK && !PAUSE) begin
            if (beat_cnt == dur) begin
              if (!end_flag) begin
                pos_n   = POS + 1'b1;
                state_n = FETCH;
              end else if (LOOP) begin
                pos_n   = SONG_BASE;
                state_n = FETCH;
              end else begin
                state_n = IDLE;
                note_n  = NOTE_NONE;
                done_n  = 1'b1;
              end
            end else begin
              cnt_n = beat_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // One-hot key display: C4 on Led[0], C5 on Led[7], silence dark, invalid all lit.
  always_comb begin
    Led = 8'h00;
    if (note < NOTE_NONE) Led = 8'h01 << (3'd7 - note[2:0]);
    else if (note != NOTE_NONE) Led = 8'hFF;
  end

  assign BUSY = (state != IDLE);

endmodule
